// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared constants for the QQVGA frame buffer read path: image geometry,
// BRAM port widths, RGB444 field layout and the colour-bar table used by
// the optional test-pattern generator (FB_TEST_PATTERN_EN).
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_IMG_W      = 160;
    localparam int FB_IMG_H      = 120;
    localparam int FB_ADDR_WIDTH = 15;
    localparam int FB_DATA_WIDTH = 12;
    localparam int FB_DEPTH      = FB_IMG_W * FB_IMG_H;
    localparam int FB_SCALE      = 4;

    // RGB444 field positions: R=[11:8], G=[7:4], B=[3:0].
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Colour bars: 8 bars, each 20 source pixels wide.
    localparam int FB_NUM_BARS = 8;
    localparam int FB_BAR_W    = FB_IMG_W / FB_NUM_BARS;

    localparam rgb444_t FB_BAR_RGB [FB_NUM_BARS] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

endpackage

// File: rtl/fb_vga_reader_if.sv
// -----------------------------------------------------------------------------
// fb_vga_reader_if
// Frame buffer read port (BRAM port B, clkb domain).
//   addrb : read address, driven by the reader
//   doutb : read data, valid one cycle after addrb
// Modports: master = reader side, slave = BRAM side.
// -----------------------------------------------------------------------------
interface fb_vga_reader_if
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int DATA_WIDTH = FB_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] doutb;

    modport master (output addrb, input  doutb);
    modport slave  (input  addrb, output doutb);
endinterface

// File: rtl/fb_sync_delay.sv
// -----------------------------------------------------------------------------
// fb_sync_delay
// N-stage shift register with a per-bit reset value; used to delay the VGA
// sync/de strobes and the in-image flag so they line up with the pixel data.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   d        : W-bit input, sampled every cycle
//   q        : d delayed by N cycles
// -----------------------------------------------------------------------------
module fb_sync_delay #(
    parameter int           N         = 3,
    parameter int           W         = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [N];

    // NOTE: these stages carry sync levels that must be idle right after
    // reset, so they are reset; a pure data store would be left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) stage[i] <= RESET_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[N-1];

endmodule

// File: rtl/fb_vga_reader.sv
// -----------------------------------------------------------------------------
// fb_vga_reader
// Read side of the QQVGA frame buffer. Follows 640x480 VGA timing, upscales
// the 160x120 RGB444 image by SCALE in both axes, generates BRAM port-B read
// addresses and emits pixel-aligned RGB plus sync/de delayed by 3 cycles.
// Optional feature macro: FB_TEST_PATTERN_EN (adds pattern_sel colour bars).
// Ports:
//   clk, rst              : VGA pixel clock (= clkb), synchronous active-high reset
//   hsync_in/vsync_in/de_in : VGA timing inputs
//   bram                  : frame buffer read port (addrb out, doutb in)
//   pattern_sel           : (FB_TEST_PATTERN_EN only) select colour bars
//   rgb_out               : registered pixel, aligned with de_out
//   hsync_out/vsync_out/de_out : timing inputs delayed by 3 cycles
//   frame_start           : one-cycle pulse on vsync_in entering its active level
// -----------------------------------------------------------------------------
module fb_vga_reader
    import fb_pkg::*;
#(
    parameter int                   DATA_WIDTH   = FB_DATA_WIDTH,
    parameter int                   IMG_W        = FB_IMG_W,
    parameter int                   IMG_H        = FB_IMG_H,
    parameter int                   ADDR_WIDTH   = FB_ADDR_WIDTH,
    parameter int                   SCALE        = FB_SCALE,
    parameter logic                 VSYNC_ACTIVE = 1'b0,
    parameter logic [DATA_WIDTH-1:0] BORDER_RGB  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  de_in,
    fb_vga_reader_if.master       bram,
`ifdef FB_TEST_PATTERN_EN
    input  logic                  pattern_sel,
`endif
    output logic [DATA_WIDTH-1:0] rgb_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  de_out,
    output logic                  frame_start
);

    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);

    localparam logic [SW-1:0]         S_LAST   = SW'(SCALE - 1);
    localparam logic [XW-1:0]         X_END    = XW'(IMG_W);
    localparam logic [XW-1:0]         X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0]         Y_END    = YW'(IMG_H);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_W);
    localparam logic                  SYNC_IDLE = ~VSYNC_ACTIVE;

    logic [SW-1:0]         xs, ys;
    logic [XW-1:0]         x_img;
    logic [YW-1:0]         y_img;
    logic [ADDR_WIDTH-1:0] row_base, addr_cur;
    logic                  frame_valid, vsync_prev, de_prev;

    logic fs_edge, line_end, in_img, xs_wrap, ys_wrap;
    logic de_d2, in_img_d2;
    logic [DATA_WIDTH-1:0] pix_rgb;

    assign fs_edge  = (vsync_in == VSYNC_ACTIVE) && (vsync_prev != VSYNC_ACTIVE);
    assign line_end = de_prev && !de_in;
    assign in_img   = de_in && frame_valid && (x_img < X_END) && (y_img < Y_END);
    assign xs_wrap  = (xs == S_LAST);
    assign ys_wrap  = (ys == S_LAST);

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            xs          <= '0;
            ys          <= '0;
            x_img       <= '0;
            y_img       <= '0;
            row_base    <= '0;
            addr_cur    <= '0;
            frame_valid <= 1'b0;
            vsync_prev  <= SYNC_IDLE;
            de_prev     <= 1'b0;
            frame_start <= 1'b0;
            bram.addrb  <= '0;
        end else begin
            vsync_prev  <= vsync_in;
            de_prev     <= de_in;
            frame_start <= fs_edge;

            // Out-of-image pixels leave addrb untouched, which also keeps it
            // inside the image because addr_cur is only used while in-image.
            if (in_img) bram.addrb <= addr_cur;

            // Frame start has priority over a coincident line end.
            if (fs_edge) begin
                xs          <= '0;
                ys          <= '0;
                x_img       <= '0;
                y_img       <= '0;
                row_base    <= '0;
                addr_cur    <= '0;
                frame_valid <= 1'b1;
            end else if (de_in) begin
                if (xs_wrap) begin
                    xs <= '0;
                    if (x_img < X_END)  x_img    <= x_img + XW'(1);
                    if (x_img < X_LAST) addr_cur <= addr_cur + ADDR_WIDTH'(1);
                end else begin
                    xs <= xs + SW'(1);
                end
            end else if (line_end) begin
                // Every source line is replayed SCALE times from row_base.
                xs    <= '0;
                x_img <= '0;
                if (ys_wrap) begin
                    ys <= '0;
                    if (y_img < Y_END) begin
                        y_img    <= y_img + YW'(1);
                        row_base <= row_base + ROW_STEP;
                        addr_cur <= row_base + ROW_STEP;
                    end else begin
                        addr_cur <= row_base;
                    end
                end else begin
                    ys       <= ys + SW'(1);
                    addr_cur <= row_base;
                end
            end
        end
    end

    fb_sync_delay #(
        .N(3), .W(3), .RESET_VAL({SYNC_IDLE, SYNC_IDLE, 1'b0})
    ) u_sync_dly (
        .clk(clk), .rst(rst),
        .d({hsync_in, vsync_in, de_in}),
        .q({hsync_out, vsync_out, de_out})
    );

    // Two stages: the third is the rgb_out register itself.
    fb_sync_delay #(
        .N(2), .W(2), .RESET_VAL(2'b00)
    ) u_img_dly (
        .clk(clk), .rst(rst),
        .d({de_in, in_img}),
        .q({de_d2, in_img_d2})
    );

`ifdef FB_TEST_PATTERN_EN
    localparam int             BPW      = $clog2(FB_BAR_W);
    localparam logic [BPW-1:0] BAR_LAST = BPW'(FB_BAR_W - 1);

    logic [BPW-1:0] bar_px;
    logic [2:0]     bar_idx;
    rgb444_t        bar_rgb;
    logic           pat_sel_d2;
    logic [11:0]    bar_rgb_d2;

    // Bar counter advances with x_img, so each bar spans FB_BAR_W source pixels.
    always_ff @(posedge clk) begin
        if (rst || fs_edge) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (de_in) begin
            if (xs_wrap && (x_img < X_END)) begin
                if (bar_px == BAR_LAST) begin
                    bar_px <= '0;
                    if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_px <= bar_px + BPW'(1);
                end
            end
        end else if (line_end) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end
    end

    assign bar_rgb = FB_BAR_RGB[bar_idx];

    fb_sync_delay #(
        .N(2), .W(13), .RESET_VAL(13'h0)
    ) u_pat_dly (
        .clk(clk), .rst(rst),
        .d({pattern_sel, bar_rgb}),
        .q({pat_sel_d2, bar_rgb_d2})
    );

    assign pix_rgb = pat_sel_d2 ? DATA_WIDTH'(bar_rgb_d2) : bram.doutb;
`else
    assign pix_rgb = bram.doutb;
`endif

    always_ff @(posedge clk) begin
        if (rst || !de_d2) rgb_out <= '0;
        else if (!in_img_d2) rgb_out <= BORDER_RGB;
        else rgb_out <= pix_rgb;
    end

endmodule

// File: tb/tb_fb_vga_reader.sv
module tb_fb_vga_reader;
    import fb_pkg::*;

    localparam int          SCALE  = 4;
    localparam int          IMG_W  = 160;
    localparam int          IMG_H  = 120;
    localparam logic        ACT    = 1'b0;
    localparam logic        IDLE   = 1'b1;
    localparam logic [11:0] BORDER = 12'h5A5;

    typedef struct {
        logic [11:0] rgb;
        logic [14:0] addr;
        bit          in_img;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (default geometry, SCALE=4) ----------------
    logic        rst, hs, vs, de;
    logic [11:0] rgb;
    logic        hso, vso, deo, fs;
`ifdef FB_TEST_PATTERN_EN
    logic        pat_sel = 1'b0;
    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif

    fb_vga_reader_if #(.ADDR_WIDTH(15), .DATA_WIDTH(12)) bram ();

    fb_vga_reader #(.SCALE(SCALE), .BORDER_RGB(BORDER)) u_dut (
        .clk(clk), .rst(rst),
        .hsync_in(hs), .vsync_in(vs), .de_in(de),
        .bram(bram),
`ifdef FB_TEST_PATTERN_EN
        .pattern_sel(pat_sel),
`endif
        .rgb_out(rgb), .hsync_out(hso), .vsync_out(vso), .de_out(deo),
        .frame_start(fs)
    );

    // ---------------- second DUT (SCALE=1, full frame fits the budget) ----
    logic        rst2, hs2, vs2, de2;
    logic [11:0] rgb2;
    logic        hso2, vso2, deo2, fs2;

    fb_vga_reader_if #(.ADDR_WIDTH(15), .DATA_WIDTH(12)) bram2 ();

    fb_vga_reader #(.SCALE(1)) u_dut_s1 (
        .clk(clk), .rst(rst2),
        .hsync_in(hs2), .vsync_in(vs2), .de_in(de2),
        .bram(bram2),
`ifdef FB_TEST_PATTERN_EN
        .pattern_sel(1'b0),
`endif
        .rgb_out(rgb2), .hsync_out(hso2), .vsync_out(vso2), .de_out(deo2),
        .frame_start(fs2)
    );

    // ---------------- BRAM model: ram[a] = a[11:0] ----------------
    logic [11:0] ram [FB_DEPTH];
    initial for (int a = 0; a < FB_DEPTH; a++) ram[a] = 12'(a);
    always @(posedge clk) bram.doutb  <= ram[bram.addrb];
    always @(posedge clk) bram2.doutb <= ram[bram2.addrb];

    // ---------------- bookkeeping ----------------
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    bit          m_fv = 0;
    int          m_line = 0, m_px = 0;
    bit          m_prev_de = 0;
    logic        m_prev_vs = IDLE;
    logic [2:0]  ep [3];
    logic        exp_fs = 1'b0;
    int          fs_exp_cnt = 0, fs_cnt = 0;
    bit          mon_en = 0;

    // One VGA cycle: drive inputs, then advance the model at the sampling edge.
    task automatic cyc(input logic h, input logic v, input logic d, input logic r);
        exp_t e;
        int   sx;
        hs = h; vs = v; de = d; rst = r;
        @(posedge clk);
        if (r) begin
            m_fv = 0; m_line = 0; m_px = 0; m_prev_de = 0; m_prev_vs = IDLE;
            for (int i = 0; i < 3; i++) ep[i] = {IDLE, IDLE, 1'b0};
            exp_fs = 1'b0;
        end else begin
            ep[2] = ep[1]; ep[1] = ep[0]; ep[0] = {h, v, d};
            exp_fs = (v == ACT) && (m_prev_vs != ACT);
            if (exp_fs) fs_exp_cnt++;
            if (d) begin
                sx       = m_px / SCALE;
                e.in_img = m_fv && (m_px < IMG_W * SCALE) && (m_line < IMG_H * SCALE);
                e.addr   = 15'((m_line / SCALE) * IMG_W + sx);
                e.rgb    = e.in_img ? ram[e.addr] : BORDER;
`ifdef FB_TEST_PATTERN_EN
                if (e.in_img && pat_sel) e.rgb = BARS[sx / 20];
`endif
                sb_q.push_back(e);
            end
            if (exp_fs) begin
                m_fv = 1; m_line = 0; m_px = 0;
            end else if (d) begin
                m_px++;
            end else if (m_prev_de) begin
                m_line++; m_px = 0;
            end
            m_prev_de = d; m_prev_vs = v;
        end
        #1;
    endtask

    task automatic vga_line(input int act, input int blank);
        for (int i = 0; i < act; i++) cyc(IDLE, IDLE, 1'b1, 1'b0);
        for (int i = 0; i < blank; i++) cyc((i >= 2 && i < 4) ? ACT : IDLE, IDLE, 1'b0, 1'b0);
    endtask

    task automatic vsync_pulse(input int len);
        for (int i = 0; i < len; i++) cyc(IDLE, ACT, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(IDLE, IDLE, 1'b0, 1'b0);
    endtask

    function automatic int rand_len();
        case ($urandom_range(0, 2))
            0:       return 640;
            1:       return 800;
            default: return int'($urandom_range(1, 639));
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [14:0] ah0 = '0, ah1 = '0;
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("sync_delay", {hso, vso, deo}, ep[2]);
            check("frame_start", fs, exp_fs);
            if (fs) fs_cnt++;
            if (deo) begin
                if (sb_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_underflow: pixel rgb=%0h with no expected entry", rgb);
                end else begin
                    e = sb_q.pop_front();
                    check("rgb_px", rgb, e.rgb);
                    if (e.in_img) check("addrb_px", ah1, e.addr);
                end
            end else begin
                check("rgb_blank", rgb, 12'h000);
            end
            ah1 = ah0;
            ah0 = bram.addrb;
        end
    end

    // ---------------- SCALE=1 full frame: address bound ----------------
    bit          done2 = 0;
    logic [14:0] max2  = '0;
    always @(negedge clk) if (!rst2 && bram2.addrb > max2) max2 = bram2.addrb;

    initial begin
        rst2 = 1'b1; hs2 = IDLE; vs2 = IDLE; de2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst2 = 1'b0;
        vs2 = ACT;
        repeat (3) @(posedge clk);
        #1 vs2 = IDLE;
        repeat (4) @(posedge clk);
        #1;
        for (int l = 0; l < IMG_H + 2; l++) begin
            de2 = 1'b1;
            repeat (IMG_W) @(posedge clk);
            #1;
            if (l == IMG_H - 1) check("s1_last_addr", bram2.addrb, FB_DEPTH - 1);
            de2 = 1'b0;
            repeat (4) @(posedge clk);
            #1;
        end
        check("s1_addr_hold", bram2.addrb, FB_DEPTH - 1);
        check("s1_addr_max", max2, FB_DEPTH - 1);
        done2 = 1;
    end

    // ---------------- main stimulus ----------------
    initial begin
        for (int i = 0; i < 4; i++) cyc(IDLE, IDLE, 1'b0, 1'b1);
        mon_en = 1;
        check("rst_addrb", bram.addrb, 0);
        check("rst_rgb", rgb, 0);

        // Frame A: full-width lines, last one over-long.
        vsync_pulse(3);
        for (int l = 0; l < 8; l++) vga_line(640, int'($urandom_range(6, 30)));
        vga_line(800, 20);

        // Frame B: random lengths, reset in a horizontal blank mid-frame.
        vsync_pulse(int'($urandom_range(2, 5)));
        for (int l = 0; l < 6; l++) vga_line(rand_len(), int'($urandom_range(6, 30)));
        cyc(IDLE, IDLE, 1'b0, 1'b1);
        check("midrst_addrb", bram.addrb, 0);
        check("midrst_rgb", rgb, 0);
        check("midrst_de", deo, 0);
        check("midrst_fs", fs, 0);
        for (int l = 0; l < 4; l++) vga_line(rand_len(), int'($urandom_range(6, 30)));

        // Frame C: ends with de falling on the same cycle as the vsync edge.
        vsync_pulse(3);
        for (int l = 0; l < 5; l++) vga_line(rand_len(), int'($urandom_range(6, 30)));
        for (int i = 0; i < 640; i++) cyc(IDLE, IDLE, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(IDLE, ACT, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(IDLE, IDLE, 1'b0, 1'b0);

        // Frame D (colour bars when the pattern feature is built in).
`ifdef FB_TEST_PATTERN_EN
        pat_sel = 1'b1;
`endif
        for (int l = 0; l < 5; l++) vga_line(640, int'($urandom_range(6, 30)));
        vsync_pulse(3);
        for (int i = 0; i < 10; i++) cyc(IDLE, IDLE, 1'b0, 1'b0);

        check("frame_start_count", fs_cnt, fs_exp_cnt);
        check("sb_drained", sb_q.size(), 0);

        for (int i = 0; i < 50000 && !done2; i++) @(posedge clk);
        if (!done2) begin
            n_tests++; n_fail++;
            $display("FAIL s1_timeout: SCALE=1 frame did not complete");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
